// File: rtl/spi_mem_arbiter_pkg.sv
// Shared types and constants for the SPI memory arbiter.
package spi_mem_pkg;

  localparam int DEFAULT_ADDR_W = 16;
  localparam logic [7:0] SPI_ERR_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/spi_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; last_grant is held by the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbitrates two read requesters onto one spi_read_byte master, with
// a CS-high gap between transactions and a timeout on a stalled master.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [7:0]        rdata,
  output logic              rerr,
  output logic              m_start,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [7:0]        m_data
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_e        state_q, state_d;
  logic              run_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              rvalid_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [1:0]        req_m;
  logic [1:0]        pick;
  logic              grant_ok;
  logic              done_hit;
  logic              timeout_hit;

  // A port still receiving its result this cycle is not re-granted.
  assign req_m = {req1, req0} & ~{rvalid1, rvalid0};

  rr_arb2 u_rr (
    .req        (req_m),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  assign rvalid0 = rvalid_q & ~owner_q;
  assign rvalid1 = rvalid_q &  owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant_ok    = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    m_start     = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        // run_q keeps grants quiet while rst_n is asserted.
        grant_ok = run_q && ena && !m_busy;
        gnt0     = grant_ok && pick[0];
        gnt1     = grant_ok && pick[1];
        if (gnt0 || gnt1) state_d = ISSUE;
      end
      ISSUE: begin
        m_start = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (m_done) begin
          done_hit = 1'b1;
          if (GAP_CYCLES == 0) state_d = IDLE;
          else                 state_d = GAP;
        end else if (to_cnt_q >= TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (!m_busy) begin
          if (GAP_CYCLES == 0) state_d = IDLE;
          else                 state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      m_addr       <= '0;
      rdata        <= '0;
      rerr         <= 1'b0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      run_q    <= 1'b1;
      rvalid_q <= done_hit || timeout_hit;

      if (gnt0) begin
        m_addr       <= addr0;
        owner_q      <= 1'b0;
        last_grant_q <= 1'b0;
      end else if (gnt1) begin
        m_addr       <= addr1;
        owner_q      <= 1'b1;
        last_grant_q <= 1'b1;
      end

      // Counts cycles since ISSUE so the error pulse lands TIMEOUT cycles after start.
      if (state_q == ISSUE)     to_cnt_q <= TO_W'(1);
      else if (state_q == WAIT) to_cnt_q <= to_cnt_q + 1'b1;

      if (done_hit) begin
        rdata <= m_data;
        rerr  <= 1'b0;
      end else if (timeout_hit) begin
        rdata <= SPI_ERR_BYTE;
        rerr  <= 1'b1;
      end

      if (state_q == GAP) gap_cnt_q <= gap_cnt_q + 1'b1;
      else                gap_cnt_q <= '0;
    end
  end

endmodule
